// File: rtl/hamming_seq_ctrl.sv
// Sequencing controller for a multi-cycle Hamming-distance core.
// Accepts one operand pair per job, clears the core accumulator, feeds
// M-bit slices LSB-first over CC cycles, then captures and holds the
// distance and its threshold comparison until the consumer accepts it.
module hamming_seq_ctrl #(
  parameter  int N  = 8,
  parameter  int CC = 4,
  localparam int M  = N / CC,
  localparam int DW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_g,
  input  logic [N-1:0]  in_e,
  input  logic [DW-1:0] in_thresh,
  output logic          core_rst,
  output logic [M-1:0]  core_g,
  output logic [M-1:0]  core_e,
  input  logic [DW-1:0] core_o,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_dist,
  output logic          out_match,
  output logic          busy
);

  // Slice counter width is at least one bit so CC=1 still has a legal counter.
  localparam int            KW     = (CC > 1) ? $clog2(CC) : 1;
  // Slice table is padded to a power of two so k_reg indexes it without range gaps.
  localparam int            NS     = 1 << KW;
  localparam logic [KW-1:0] K_LAST = KW'(CC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [KW-1:0]   k_reg;
  logic [N-1:0]    g_reg;
  logic [N-1:0]    e_reg;
  logic [DW-1:0]   thresh_reg;
  logic [M-1:0]    g_slice [NS];
  logic [M-1:0]    e_slice [NS];

  // Split the latched operands into LSB-first slices; padding entries read as zero.
  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_slices
      if (gi < CC) begin : g_used
        assign g_slice[gi] = g_reg[gi*M +: M];
        assign e_slice[gi] = e_reg[gi*M +: M];
      end else begin : g_pad
        assign g_slice[gi] = '0;
        assign e_slice[gi] = '0;
      end
    end
  endgenerate

  // Status and core-facing decodes of the state register.
  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg == CLEAR) || (state_reg == RUN);
  // Reset also clears the core so an aborted job leaves no residue.
  assign core_rst = rst || (state_reg == CLEAR);
  assign core_g   = (state_reg == RUN) ? g_slice[k_reg] : '0;
  assign core_e   = (state_reg == RUN) ? e_slice[k_reg] : '0;

  // Job sequencing: accept, clear core, stream slices, capture and hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      k_reg      <= '0;
      g_reg      <= '0;
      e_reg      <= '0;
      thresh_reg <= '0;
      out_dist   <= '0;
      out_match  <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            g_reg      <= in_g;
            e_reg      <= in_e;
            thresh_reg <= in_thresh;
            k_reg      <= '0;
            state_reg  <= CLEAR;
          end
        end
        CLEAR: begin
          state_reg <= RUN;
        end
        RUN: begin
          if (k_reg == K_LAST) begin
            // core_o already includes the final slice's contribution.
            out_dist  <= core_o;
            out_match <= (core_o <= thresh_reg);
            out_valid <= 1'b1;
            state_reg <= DONE;
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Bench for hamming_seq_ctrl: N=8/CC=4 instance plus an N=8/CC=1 instance,
// each driving a behavioural XOR/COUNT/ADD accumulator core.
module tb_hamming_seq_ctrl;

  localparam int N  = 8;
  localparam int CC = 4;
  localparam int M  = 2;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_g;
  logic [N-1:0]  in_e;
  logic [DW-1:0] in_thresh;
  logic          core_rst;
  logic [M-1:0]  core_g;
  logic [M-1:0]  core_e;
  logic [DW-1:0] core_o;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_dist;
  logic          out_match;
  logic          busy;

  // CC=1 instance signals
  logic          in_valid1;
  logic          in_ready1;
  logic [N-1:0]  in_g1;
  logic [N-1:0]  in_e1;
  logic [DW-1:0] in_thresh1;
  logic          core_rst1;
  logic [N-1:0]  core_g1;
  logic [N-1:0]  core_e1;
  logic [DW-1:0] core_o1;
  logic          out_valid1;
  logic          out_ready1;
  logic [DW-1:0] out_dist1;
  logic          out_match1;
  logic          busy1;

  always #5 clk = ~clk;

  hamming_seq_ctrl #(.N(N), .CC(CC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_g(in_g), .in_e(in_e), .in_thresh(in_thresh), .core_rst(core_rst),
    .core_g(core_g), .core_e(core_e), .core_o(core_o), .out_valid(out_valid),
    .out_ready(out_ready), .out_dist(out_dist), .out_match(out_match), .busy(busy)
  );

  hamming_seq_ctrl #(.N(N), .CC(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_g(in_g1), .in_e(in_e1), .in_thresh(in_thresh1), .core_rst(core_rst1),
    .core_g(core_g1), .core_e(core_e1), .core_o(core_o1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_dist(out_dist1), .out_match(out_match1), .busy(busy1)
  );

  // Behavioural accumulator cores: running distance includes the current slice.
  logic [DW-1:0] acc_reg, acc1_reg;
  always_comb core_o  = acc_reg  + DW'($countones(core_g ^ core_e));
  always_comb core_o1 = acc1_reg + DW'($countones(core_g1 ^ core_e1));
  always_ff @(posedge clk) begin
    acc_reg  <= core_rst  ? '0 : core_o;
    acc1_reg <= core_rst1 ? '0 : core_o1;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] g;
    logic [7:0] e;
    logic [3:0] thr;
    logic [3:0] exp_dist;
    logic       exp_match;
  } vec_t;

  vec_t vecs [9];

  // Full job on the CC=4 instance, checking slices, latency, result and handshake.
  task automatic run_job(input vec_t v);
    int w;
    int lat;
    int si;
    logic [7:0] sh;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("in_ready_before_job", int'(in_ready), 1);
    in_g      = v.g;
    in_e      = v.e;
    in_thresh = v.thr;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_g      = 8'h5A;
    in_e      = 8'hC3;
    in_thresh = 4'd0;
    check("clear_core_rst", int'(core_rst), 1);
    check("clear_in_ready", int'(in_ready), 0);
    lat = 0;
    si  = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      if (busy && !core_rst && si < CC) begin
        sh = v.g >> (2 * si);
        check("core_g_slice", int'(core_g), int'(sh[1:0]));
        si++;
      end
    end
    check("latency", lat, CC + 1);
    check("out_dist", int'(out_dist), int'(v.exp_dist));
    check("out_match", int'(out_match), int'(v.exp_match));
    check("done_in_ready", int'(in_ready), 0);
    $display("job g=%h e=%h thr=%0d -> dist=%0d match=%0d latency=%0d",
             v.g, v.e, v.thr, out_dist, out_match, lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", int'(out_valid), 0);
    check("post_hs_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    logic [3:0] held_dist;
    logic       held_match;
    int lat;

    vecs[0] = '{8'hFF, 8'h00, 4'd3,  4'd8, 1'b0};
    vecs[1] = '{8'hA5, 8'hA5, 4'd0,  4'd0, 1'b1};
    vecs[2] = '{8'h0F, 8'h00, 4'd4,  4'd4, 1'b1};
    vecs[3] = '{8'h01, 8'h00, 4'd0,  4'd1, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 4'd8,  4'd8, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 4'd15, 4'd8, 1'b1};
    vecs[6] = '{8'h5A, 8'hA5, 4'd7,  4'd8, 1'b0};
    vecs[7] = '{8'h12, 8'h34, 4'd2,  4'd3, 1'b0};
    vecs[8] = '{8'h00, 8'h00, 4'd0,  4'd0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_g = '0; in_e = '0; in_thresh = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_g1 = '0; in_e1 = '0; in_thresh1 = '0; out_ready1 = 1'b0;
    tick();
    tick();
    check("rst_core_rst", int'(core_rst), 1);
    rst = 1'b0;
    tick();
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_dist", int'(out_dist), 0);
    check("reset_out_match", int'(out_match), 0);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_core_rst", int'(core_rst), 0);
    check("idle_core_g", int'(core_g), 0);

    // Table of jobs, issued back to back.
    for (int i = 0; i < 9; i++) begin
      run_job(vecs[i]);
    end

    // Held result in DONE while consumer stalls and inputs churn.
    in_g = 8'h3C; in_e = 8'h00; in_thresh = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("stall_latency", lat, CC + 1);
    held_dist  = out_dist;
    held_match = out_match;
    check("stall_dist", int'(held_dist), 4);
    check("stall_match", int'(held_match), 1);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_g     = 8'(c * 37);
      tick();
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_dist_hold", int'(out_dist), int'(held_dist));
      check("stall_match_hold", int'(out_match), int'(held_match));
      check("stall_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release_idle", int'(in_ready), 1);
    check("stall_release_valid", int'(out_valid), 0);
    $display("stall job g=3c dist=%0d match=%0d released", held_dist, held_match);

    // Reset in the middle of RUN (k=2) aborts the job.
    in_g = 8'hFF; in_e = 8'h00; in_thresh = 4'd8; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("abort_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_core_rst_comb", int'(core_rst), 1);
    tick();
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_core_rst_held", int'(core_rst), 1);
    rst = 1'b0;
    tick();
    check("abort_no_result", int'(out_valid), 0);
    $display("abort job during RUN k=2");
    run_job('{8'h03, 8'h00, 4'd2, 4'd2, 1'b1});

    // CC=1 instance: single RUN cycle.
    in_g1 = 8'h81; in_e1 = 8'h00; in_thresh1 = 4'd2; in_valid1 = 1'b1;
    check("cc1_in_ready", int'(in_ready1), 1);
    tick();
    in_valid1 = 1'b0;
    check("cc1_clear", int'(core_rst1), 1);
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      tick();
      lat++;
    end
    check("cc1_latency", lat, 2);
    check("cc1_dist", int'(out_dist1), 2);
    check("cc1_match", int'(out_match1), 1);
    $display("cc1 job g=81 e=00 thr=2 -> dist=%0d match=%0d latency=%0d",
             out_dist1, out_match1, lat);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("cc1_post_hs", int'(in_ready1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
